// File: rtl/rc4_pkg.sv
// rc4_pkg: shared RC4 key-schedule types and sizes
package rc4_pkg;

    localparam int S_SIZE      = 256;
    localparam int KEY_LEN_DEF = 3;

    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        WAIT_I,
        CALC_J,
        RD_J,
        WAIT_J,
        WR_I,
        WR_J,
        DONE
    } state_t;

endpackage

// File: rtl/ksa_swap_fsm.sv
// ksa_swap_fsm: RC4 key-schedule swap loop over an external 256x8 S-memory
module ksa_swap_fsm
    import rc4_pkg::*;
#(
    parameter int KEY_LEN = KEY_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [8*KEY_LEN-1:0] secret_key,
    output logic [7:0]           mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 mem_wren,
    input  logic [7:0]           mem_rdata,
    output logic                 busy,
    output logic                 fin_strobe
);

    localparam int            KW     = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(KEY_LEN - 1);
    localparam logic [7:0]    I_LAST = 8'(S_SIZE - 1);

    state_t               r_state, w_next;
    logic [7:0]           r_i, r_j, r_si, r_sj;
    logic [KW-1:0]        r_k;
    logic [8*KEY_LEN-1:0] r_key;
    logic                 r_fin;
    logic [7:0]           w_kb;

    // byte 0 is the most significant byte of the key
    assign w_kb = 8'(r_key >> (8 * (KEY_LEN - 1 - int'(r_k))));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_si    <= '0;
            r_sj    <= '0;
            r_k     <= '0;
            r_key   <= '0;
            r_fin   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_fin   <= (r_state == WR_J) && (r_i == I_LAST);
            case (r_state)
                IDLE: if (start) begin
                    r_key <= secret_key;
                    r_i   <= '0;
                    r_j   <= '0;
                    r_k   <= '0;
                end
                WAIT_I: r_si <= mem_rdata;
                CALC_J: r_j <= r_j + r_si + w_kb;
                WAIT_J: r_sj <= mem_rdata;
                WR_J: if (r_i != I_LAST) begin
                    r_i <= r_i + 8'd1;
                    r_k <= (r_k == K_LAST) ? '0 : r_k + KW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? RD_I : IDLE;
            RD_I:    w_next = WAIT_I;
            WAIT_I:  w_next = CALC_J;
            CALC_J:  w_next = RD_J;
            RD_J:    w_next = WAIT_J;
            WAIT_J:  w_next = WR_I;
            WR_I:    w_next = WR_J;
            WR_J:    w_next = (r_i == I_LAST) ? DONE : RD_I;
            DONE:    w_next = start ? DONE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign busy       = r_state inside {RD_I, WAIT_I, CALC_J, RD_J, WAIT_J, WR_I, WR_J};
    assign mem_wren   = r_state inside {WR_I, WR_J};
    assign mem_addr   = (r_state inside {RD_I, WAIT_I, WR_I}) ? r_i :
                        (r_state inside {RD_J, WAIT_J, WR_J}) ? r_j : 8'd0;
    assign mem_wdata  = (r_state == WR_I) ? r_sj : (r_state == WR_J) ? r_si : 8'd0;
    assign fin_strobe = r_fin;

endmodule
